// File: rtl/encoder_pkg.sv
// Shared types and the quadrature Gray-code sequence for the encoder block.
package encoder_pkg;

    typedef logic [1:0] ab_t;

    localparam ab_t AB_00 = 2'b00;
    localparam ab_t AB_01 = 2'b01;
    localparam ab_t AB_11 = 2'b11;
    localparam ab_t AB_10 = 2'b10;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    // Clockwise successor in {A,B} order: 00 -> 01 -> 11 -> 10 -> 00.
    function automatic ab_t next_up(input ab_t ab);
        case (ab)
            AB_00:   next_up = AB_01;
            AB_01:   next_up = AB_11;
            AB_11:   next_up = AB_10;
            default: next_up = AB_00;
        endcase
    endfunction

endpackage

// File: rtl/encoder_sync_filter.sv
// One encoder channel: multi-flop synchroniser, plus a stability filter when
// ENCODER_FILTER_EN is defined.
module encoder_sync_filter #(
    parameter int SYNC_STAGES = 2
`ifdef ENCODER_FILTER_EN
    , parameter int FILTER_LEN = 4
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

`ifdef ENCODER_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN) + 1;

    logic [FW-1:0] cnt_q, cnt_d;
    logic          filt_q, filt_d;

    // cnt tracks how long the synchronised input has disagreed with the output.
    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync_q[SYNC_STAGES-1] == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = sync_q[SYNC_STAGES-1];
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign dout = filt_q;
`else
    assign dout = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/encoder.sv
// Quadrature A/B decoder with 4x counting, illegal-transition flags and arming.
// Optional glitch filter on each channel: ENCODER_FILTER_EN.
module encoder
    import encoder_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    output logic [CNT_W-1:0] position,
    output logic             step,
    output logic             dir,
    output logic             err,
    output logic             err_flag
);

`ifdef ENCODER_FILTER_EN
    localparam int FILT_EN = 1;
`else
    localparam int FILT_EN = 0;
`endif
    // Long enough for reset-time pin levels to reach prev without being decoded.
    localparam int ARM_CYCLES = SYNC_STAGES + 1 + FILT_EN * FILTER_LEN;
    localparam int AW         = $clog2(ARM_CYCLES + 1);

    logic a_s, b_s;
    ab_t  s;

    encoder_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef ENCODER_FILTER_EN
        , .FILTER_LEN(FILTER_LEN)
`endif
    ) u_sync_a (.clk(clk), .rst_n(rst_n), .din(enc_a), .dout(a_s));

    encoder_sync_filter #(
        .SYNC_STAGES(SYNC_STAGES)
`ifdef ENCODER_FILTER_EN
        , .FILTER_LEN(FILTER_LEN)
`endif
    ) u_sync_b (.clk(clk), .rst_n(rst_n), .din(enc_b), .dout(b_s));

    assign s = {a_s, b_s};

    ab_t              prev_q, prev_d;
    logic [AW-1:0]    arm_q, arm_d;
    logic [CNT_W-1:0] pos_q, pos_d;
    logic             step_q, step_d;
    dir_t             dir_q, dir_d;
    logic             err_q, err_d;
    logic             err_flag_q, err_flag_d;
    logic             armed, is_up, is_dn, is_bad;

    always_comb begin
        prev_d     = s;
        arm_d      = arm_q;
        pos_d      = pos_q;
        step_d     = 1'b0;
        dir_d      = dir_q;
        err_d      = 1'b0;
        err_flag_d = err_flag_q;

        armed  = (arm_q == AW'(ARM_CYCLES));
        is_up  = (s == next_up(prev_q));
        is_dn  = (prev_q == next_up(s));
        is_bad = (s == ~prev_q);

        if (!armed) begin
            arm_d = arm_q + 1'b1;
        end else if (is_up) begin
            pos_d  = pos_q + 1'b1;
            step_d = 1'b1;
            dir_d  = DIR_UP;
        end else if (is_dn) begin
            pos_d  = pos_q - 1'b1;
            step_d = 1'b1;
            dir_d  = DIR_DOWN;
        end else if (is_bad) begin
            err_d      = 1'b1;
            err_flag_d = 1'b1;
        end

        // Clear wins over counting; an illegal edge in the same cycle still latches.
        if (clr) begin
            pos_d      = '0;
            err_flag_d = err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= AB_00;
            arm_q      <= '0;
            pos_q      <= '0;
            step_q     <= 1'b0;
            dir_q      <= DIR_DOWN;
            err_q      <= 1'b0;
            err_flag_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            arm_q      <= arm_d;
            pos_q      <= pos_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign position = pos_q;
    assign step     = step_q;
    assign dir      = dir_q;
    assign err      = err_q;
    assign err_flag = err_flag_q;

endmodule

// File: tb/tb_encoder.sv
// Directed bench for encoder: reset/arming, up/down counting, illegal edges,
// clear priority, 16-bit wrap, mid-run reset, and the optional glitch filter.
module tb_encoder;

`ifdef ENCODER_FILTER_EN
    localparam int LAT = 2 + 4;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enc_a = 1'b0;
    logic        enc_b = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] position;
    logic        step, dir, err, err_flag;

    int n_chk = 0;
    int n_fail = 0;
    int step_cnt = 0;
    int err_cnt = 0;
    int idx = 0;
    logic [1:0] lut [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    encoder #(.CNT_W(16), .SYNC_STAGES(2), .FILTER_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
        .position(position), .step(step), .dir(dir), .err(err), .err_flag(err_flag)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && step) step_cnt++;
        if (rst_n && err)  err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        {enc_a, enc_b} = lut[idx];
    endtask

    task automatic move(input int delta, input int gap);
        @(negedge clk);
        idx = (idx + delta) % 4;
        drive();
        repeat (gap) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(negedge clk) clr = 1'b1;
        @(negedge clk) clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with both pins high.
        idx = 2;
        drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_position", 32'(position), 32'h0);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_dir", 32'(dir), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_err_flag", 32'(err_flag), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("arm_no_step", 32'(step_cnt), 32'd0);
        chk("arm_no_err", 32'(err_cnt), 32'd0);
        chk("arm_position", 32'(position), 32'h0);

        // 11 -> 10 -> 00 is two up steps, then clear.
        move(1, 5);
        move(1, 5);
        chk("prime_position", 32'(position), 32'h2);
        chk("prime_dir", 32'(dir), 32'h1);
        pulse_clr();
        chk("clr_position", 32'(position), 32'h0);

        // Up sequence 00->01->11->10->00, first step timed exactly.
        step_cnt = 0;
        @(negedge clk);
        idx = (idx + 1) % 4;
        drive();
        repeat (LAT) @(posedge clk);
        #1 chk("lat_before", 32'(step), 32'h0);
        @(posedge clk);
        #1 chk("lat_step", 32'(step), 32'h1);
        chk("lat_position", 32'(position), 32'h1);
        @(posedge clk);
        #1 chk("lat_after", 32'(step), 32'h0);
        move(1, 5);
        move(1, 5);
        move(1, 5);
        chk("up_steps", 32'(step_cnt), 32'd4);
        chk("up_position", 32'(position), 32'h4);
        chk("up_dir", 32'(dir), 32'h1);
        chk("up_no_err", 32'(err_cnt), 32'd0);

        // Illegal 00 -> 11.
        move(2, LAT + 4);
        chk("bad_err_pulses", 32'(err_cnt), 32'd1);
        chk("bad_err_flag", 32'(err_flag), 32'h1);
        chk("bad_position", 32'(position), 32'h4);
        chk("bad_dir", 32'(dir), 32'h1);
        chk("bad_no_step", 32'(step_cnt), 32'd4);
        pulse_clr();
        chk("clr_err_flag", 32'(err_flag), 32'h0);
        chk("clr2_position", 32'(position), 32'h0);

        // Down sequence 11->01->00->10->11 from zero.
        move(3, 5);
        move(3, 5);
        move(3, 5);
        move(3, 5);
        chk("dn_steps", 32'(step_cnt), 32'd8);
        chk("dn_position", 32'(position), 32'hFFFC);
        chk("dn_dir", 32'(dir), 32'h0);

        // Clear coincident with an up step.
        @(negedge clk);
        idx = (idx + 1) % 4;
        drive();
        repeat (LAT) @(posedge clk);
        @(negedge clk) clr = 1'b1;
        @(posedge clk);
        #1 chk("clrstep_step", 32'(step), 32'h1);
        chk("clrstep_position", 32'(position), 32'h0);
        chk("clrstep_dir", 32'(dir), 32'h1);
        @(negedge clk) clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("clrstep_hold", 32'(position), 32'h0);

`ifndef ENCODER_FILTER_EN
        // Legal edge every cycle up to the positive limit, then wrap both ways.
        step_cnt = 0;
        for (int i = 0; i < 32767; i++) begin
            @(negedge clk);
            idx = (idx + 1) % 4;
            drive();
        end
        repeat (LAT + 2) @(posedge clk);
        #1 chk("fast_position", 32'(position), 32'h7FFF);
        chk("fast_steps", 32'(step_cnt), 32'd32767);
        chk("fast_no_err", 32'(err_cnt), 32'd1);
        move(1, LAT + 3);
        chk("wrap_up", 32'(position), 32'h8000);
        move(3, LAT + 3);
        chk("wrap_down", 32'(position), 32'h7FFF);
        chk("wrap_dir", 32'(dir), 32'h0);
`endif

        // Reset mid-operation; pins jump diagonally while in reset.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("midrst_position", 32'(position), 32'h0);
        chk("midrst_dir", 32'(dir), 32'h0);
        chk("midrst_step", 32'(step), 32'h0);
        idx = (idx + 2) % 4;
        drive();
        step_cnt = 0;
        err_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 chk("rearm_no_step", 32'(step_cnt), 32'd0);
        chk("rearm_no_err", 32'(err_cnt), 32'd0);
        chk("rearm_err_flag", 32'(err_flag), 32'h0);
        move(1, LAT + 4);
        chk("rearm_up", 32'(position), 32'h1);

`ifdef ENCODER_FILTER_EN
        // Two-cycle glitch on A is dropped; a six-cycle level counts once.
        step_cnt = 0;
        @(negedge clk) enc_a = ~enc_a;
        repeat (2) @(negedge clk);
        enc_a = ~enc_a;
        repeat (15) @(posedge clk);
        #1 chk("glitch_no_step", 32'(step_cnt), 32'd0);
        chk("glitch_position", 32'(position), 32'h1);
        @(negedge clk) enc_a = ~enc_a;
        repeat (6) @(negedge clk);
        repeat (10) @(posedge clk);
        #1 chk("level_one_step", 32'(step_cnt), 32'd1);
        chk("level_no_err", 32'(err_cnt), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
